// File: rtl/string_stream_ctrl.sv
// Purpose: round-robin shares one string ROM among NUM_REQ clients and streams the selected string one character per beat (STRING_STREAM_TRIM_EN drops trailing spaces).
// Latency: grant 1 cycle after req is seen in IDLE, first beat 1 cycle later, done 2+beats cycles after the request with char_ready high.
// Backpressure: char_ready=0 stalls the stream with every char_* output held; accepted beats are back to back with no bubbles.
module string_stream_ctrl #(
    parameter int STRING_NUM = 13,
    parameter int MAX_CHAR   = 11,
    parameter int CHAR_WIDTH = 5,
    parameter int NUM_REQ    = 4,
    parameter int SPACE_CODE = 31,
    parameter int AW         = $clog2(STRING_NUM + 1),
    parameter int IW         = $clog2(MAX_CHAR),
    parameter int SW         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*AW-1:0]          req_addr,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           req_err,
    output logic [AW-1:0]                  rom_addr,
    input  logic [CHAR_WIDTH*MAX_CHAR-1:0] rom_string,
    output logic                           char_valid,
    input  logic                           char_ready,
    output logic [CHAR_WIDTH-1:0]          char_code,
    output logic [IW-1:0]                  char_idx,
    output logic [SW-1:0]                  char_src,
    output logic                           char_last
);

    localparam int            TW         = CHAR_WIDTH * MAX_CHAR;
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(STRING_NUM);
    localparam logic [IW-1:0] IDX_MAX    = IW'(MAX_CHAR - 1);

`ifdef STRING_STREAM_TRIM_EN
    localparam bit TRIM_EN = 1'b1;
`else
    localparam bit TRIM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] rr_ptr;
    logic [TW-1:0] shreg;
    logic [IW-1:0] last_idx;
    logic [IW-1:0] last_nxt;
    logic          any_char;
    logic          pick_vld;
    logic [SW-1:0] pick_idx;
    logic [AW-1:0] pick_addr;
    logic          addr_bad;
    logic          beat_acc;
    int            cand;

    // First requesting client at or after the round-robin pointer, with wrap.
    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_addr = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!pick_vld && req[cand]) begin
                pick_vld  = 1'b1;
                pick_idx  = SW'(cand);
                pick_addr = req_addr[cand*AW +: AW];
            end
        end
    end

    // Index of the final streamed character; with trimming it is the last non-space field.
    always_comb begin
        last_nxt = IDX_MAX;
        any_char = 1'b1;
        if (TRIM_EN) begin
            last_nxt = '0;
            any_char = 1'b0;
            for (int k = 0; k < MAX_CHAR; k++) begin
                if (rom_string[TW-1-k*CHAR_WIDTH -: CHAR_WIDTH] != CHAR_WIDTH'(SPACE_CODE)) begin
                    last_nxt = IW'(k);
                    any_char = 1'b1;
                end
            end
        end
    end

    assign addr_bad   = (rom_addr >= ADDR_LIMIT);
    assign char_valid = (state == STREAM);
    assign beat_acc   = char_valid & char_ready;
    assign char_code  = shreg[TW-1 -: CHAR_WIDTH];
    assign char_last  = char_valid && (char_idx == last_idx);
    assign done       = grant & {NUM_REQ{state == DONE}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = FETCH;
            FETCH:   state_nxt = (addr_bad || !any_char) ? DONE : STREAM;
            STREAM:  if (beat_acc && char_idx == last_idx) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            req_err  <= 1'b0;
            rom_addr <= '0;
            char_src <= '0;
            char_idx <= '0;
            last_idx <= '0;
            shreg    <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant    <= NUM_REQ'(1) << pick_idx;
                        char_src <= pick_idx;
                        rom_addr <= pick_addr;
                    end
                end
                FETCH: begin
                    char_idx <= '0;
                    last_idx <= last_nxt;
                    if (addr_bad) begin
                        req_err <= 1'b1;
                    end else begin
                        shreg <= rom_string;
                    end
                end
                STREAM: begin
                    // char_idx parks on the last index so it never leaves 0..MAX_CHAR-1.
                    if (beat_acc) begin
                        shreg <= shreg << CHAR_WIDTH;
                        if (char_idx != last_idx) begin
                            char_idx <= char_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    grant   <= '0;
                    req_err <= 1'b0;
                    rr_ptr  <= (char_src == SW'(NUM_REQ - 1)) ? '0 : char_src + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/string_stream_ctrl.md
Name: string_stream_ctrl

Overview:
- Shares the single string ROM between NUM_REQ display clients (menu, HUD, timer overlay, and so on).
- Round-robin arbitration picks a client; the block drives the ROM address, captures the packed string and streams it one character per beat to the character-tile writer over a valid/ready handshake.
- Returns a per-client done pulse, plus an error flag for out-of-range addresses.

Parameters:
- STRING_NUM, 13, number of strings in the ROM.
- MAX_CHAR, 11, characters per string.
- CHAR_WIDTH, 5, bits per character code.
- NUM_REQ, 4, number of requesting clients (2..8).
- SPACE_CODE, 31, code for the blank character.
- Derived: AW = $clog2(STRING_NUM+1); IW = $clog2(MAX_CHAR); SW = $clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-client request, level; bit i = client i.
- req_addr  in  NUM_REQ*AW  per-client string index; client i at [i*AW +: AW].
- grant  out  NUM_REQ  one-hot owner of the ROM/stream.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_err  out  1  qualifies done: the address was ≥ STRING_NUM.
- rom_addr  out  AW  to the string ROM.
- rom_string  in  CHAR_WIDTH*MAX_CHAR  from the string ROM (combinational).
- char_valid  out  1  character beat valid.
- char_ready  in  1  sink accepts beat.
- char_code  out  CHAR_WIDTH  character code.
- char_idx  out  IW  position in the string, 0..MAX_CHAR-1.
- char_src  out  SW  owning client index.
- char_last  out  1  final beat of the string.

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - state=IDLE.
  - grant, done, req_err, char_valid, char_last = 0.
  - rom_addr, char_code, char_idx, char_src = 0.
  - RR pointer = 0.
  - Reset mid-stream aborts the transfer; no done is issued.
- Character order: index 0 = rom_string[CHAR_WIDTH*MAX_CHAR-1 -: CHAR_WIDTH] (MSB first); index k is the next field down.
- FSM states: IDLE, FETCH, STREAM, DONE.
- IDLE:
  - If any req bit is set, select the first set bit at or after the RR pointer, with wrap.
  - Register grant (one-hot), char_src, and rom_addr = that client's req_addr. Go to FETCH.
- FETCH (1 cycle):
  - rom_addr is stable; capture rom_string into a shift register at the cycle end.
  - If rom_addr ≥ STRING_NUM, skip the capture, set req_err=1 and go to DONE.
  - Otherwise go to STREAM with char_idx=0.
- STREAM:
  - char_valid=1; char_code = current head field; char_last = (char_idx == MAX_CHAR-1).
  - A beat is accepted on char_valid & char_ready. On acceptance, shift the register and increment char_idx.
  - When char_ready=0, all char_* outputs hold steady. No bubbles between accepted beats.
  - The cycle after the last beat is accepted: char_valid=0, go to DONE.
- DONE (1 cycle):
  - done[owner]=1; req_err valid this cycle only.
  - The next cycle: grant=0, done=0, req_err=0, RR pointer = owner+1 mod NUM_REQ, go to IDLE.
- Latency: req seen in IDLE at cycle 0 → grant at cycle 1 → first char_valid at cycle 2 → done at cycle 2+MAX_CHAR with ready held high. Minimum 14 cycles per string with defaults.
- Request lines:
  - req and req_addr are sampled only in IDLE.
  - Dropping req mid-transfer is ignored; the string completes.
  - A client holding req after done competes again; RR ordering prevents starvation.
- Simultaneous requests: only one grant; the others wait. The IDLE→FETCH decision takes one cycle, so back-to-back strings have a 2-cycle gap (DONE, IDLE).

Optional Feature:
- Macro STRING_STREAM_TRIM_EN.
- Defined: trailing SPACE_CODE characters are not streamed.
  - During FETCH, compute the last non-space index L; char_last asserts at idx L.
  - An all-space string emits zero beats and goes FETCH→DONE with req_err=0.
- Undefined: all MAX_CHAR characters are always streamed.

Test Plan:
- Single request, ready high, defaults: client 0, addr 0 → beats 6,0,12,4,31,19,8,12,4,26,31 at idx 0..10; char_last on idx 10; done[0] at cycle 13; grant clears at cycle 14.
- Back-pressure: addr 12, char_ready toggled 1/0 → codes 8,13,18,19,17,20,2,19,8,14,13 with no loss or duplication; outputs stable while ready=0.
- Arbitration: req=4'b1011 held continuously → grant order 0,1,3,0,…; char_src matches each grant; no overlap between grants.
- Error: client 2, addr 13 → no char_valid; done[2]=1 with req_err=1 exactly one cycle.
- Reset mid-stream: rst_n low at idx 5 → all outputs 0 immediately. After release, a new request streams from idx 0.
- With STRING_STREAM_TRIM_EN:
  - addr 0 → 10 beats, last code 26 at idx 9.
  - addr 5 (all code 27) → 11 beats, unchanged.
